keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Input-side counterpart of the four-digit LED driver. It scans a 4x4 matrix keypad by driving one column low at a time, the way the driver multiplexes anodes, and reads the synchronised rows. A key is accepted only after a debounce period. Each new press is reported once as a 4-bit key code with a one-cycle valid pulse, which feeds the message/scroll logic in place of the single button.

## Interface
- SCAN_DIV, default 4: clock cycles each column is driven before its rows are sampled; must be ≥ 4
- DEBOUNCE_CNT, default 3: consecutive identical samples required to accept a press or a release; must be ≥ 1
- clk  input  1  single system clock
- reset  input  1  asynchronous, active-low reset
- row  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk
- col  output  4  keypad columns, one-hot active-low; only one bit is 0 at any time
- key  output  4  code of last accepted key, {row_idx[1:0], col_idx[1:0]}
- key_valid  output  1  one-cycle pulse when key is updated
- key_held  output  1  high while accepted key remains pressed

## Operation
- row passes through a 2-flop synchroniser (sub-module); all decisions use the synchronised value rs.
- Dwell counter counts 0..SCAN_DIV-1. A sample is taken when the counter equals SCAN_DIV-1, giving at least 2 cycles of settling after a column change.
- States:
  - SCAN: sample with rs == 4'b1111: advance col_idx (3 wraps to 0) and restart dwell. Sample with any row low: latch cand_row = lowest-index low row and cand_col = col_idx; match count = 1; go to DEBOUNCE; col stays.
  - DEBOUNCE: rs[cand_row] == 0 at sample: match count +1. rs[cand_row] == 1: return to SCAN and advance col_idx. When match count reaches DEBOUNCE_CNT: key ← {cand_row, cand_col}, key_valid pulse, key_held ← 1, go to HELD. DEBOUNCE_CNT = 1 accepts on the first detection sample.
  - HELD: col stays on cand_col. Each sample with rs == 4'b1111 increments the release count; any sample with a row low clears it. When release count reaches DEBOUNCE_CNT: key_held ← 0, advance col_idx, go to SCAN.
- Other keys pressed in HELD are ignored, including keys in the same column on different rows; no rollover.
- Several rows low at detection: lowest index wins.
- key keeps its last value until the next accepted press.

## Timing
- Reset values: col = 4'b1110, key = 4'h0, key_valid = 0, key_held = 0, state SCAN, dwell/match/release counts 0.
- Reset asserted mid-operation returns everything to the values above immediately; a key still held after release of reset is detected again as a new press.
- key, key_valid and key_held change together, one cycle after the accepting sample edge; all outputs are registered.
- Press-to-valid latency, key in the currently driven column, held steady: 2 (sync) + up to SCAN_DIV (to the next sample) + (DEBOUNCE_CNT-1)·SCAN_DIV + 1 cycles.
- Worst-case detection delay adds 3·SCAN_DIV for the scan to reach the key's column.
- key_valid is never high on two consecutive cycles.

## Structure
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, HELD}
  - localparams NCOL = 4, NROW = 4, COL_IDLE = 4'b1111
- Sub-module row_sync: 4-bit 2-flop synchroniser with asynchronous active-low reset to 4'b1111.
- FSM, dwell counter, match/release counters and output registers sit in keypad_scanner.
- Counter widths: $clog2(SCAN_DIV) and $clog2(DEBOUNCE_CNT+1).

## Test plan
All cases use SCAN_DIV = 4 and DEBOUNCE_CNT = 3. The bench models the keypad as row[r] = col[c] when key (r,c) is pressed.
- No key pressed for 64 cycles → col cycles 1110, 1101, 1011, 0111, each for 4 cycles; key_valid stays 0.
- Press (r=2, c=1) and hold → exactly one key_valid pulse with key = 4'b1001; key_held = 1; col frozen at 1101.
- Glitch: press (1,3) for 6 cycles, then release → no key_valid; scan resumes at column 0.
- Release after acceptance → key_held falls 3 samples after the rows read all-high; key stays 4'b0111-style last value (here 4'b1001); col then advances to 1011.
- Press (0,2) and (3,2) together → key = 4'b0010. Adding (1,0) during HELD produces no pulse.
- Assert reset during DEBOUNCE and during HELD → all outputs return to reset values at once; after reset releases with the key still down, the key is re-accepted with one pulse.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  localparam int NCOL = 4;
  localparam int NROW = 4;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Index of the lowest-numbered row that reads low (rows are active-low).
  function automatic logic [1:0] lowest_low(input logic [NROW-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int i = NROW - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // One-hot active-low column drive pattern for a column index.
  function automatic logic [NCOL-1:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-report signals of the scanner, bundled together.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NROW-1:0] row;
  logic [NCOL-1:0] col;
  logic [3:0]      key;
  logic            key_valid;
  logic            key_held;

  modport master (
    input  row,
    output col,
    output key,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad rows; idles all-high.
module row_sync
  import keypad_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NROW-1:0] row,
  output logic [NROW-1:0] rs
);

  logic [NROW-1:0] meta;

  // Two register stages; reset to "no key" so nothing is seen as pressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      rs   <= '1;
    end else begin
      meta <= row;
      rs   <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, debounces press and release,
// and reports each accepted key once with a single-cycle valid pulse.
// The reset input is asynchronous and active-low.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic clk,
  input  logic reset,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam int IW = $clog2(NCOL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CNT);

  logic [NROW-1:0] rs;

  state_t          state, state_next;
  logic [DW-1:0]   dwell;
  logic [IW-1:0]   col_idx, col_idx_next;
  logic [1:0]      cand_row, cand_row_next;
  logic [IW-1:0]   cand_col, cand_col_next;
  logic [CW-1:0]   match_cnt, match_next;
  logic [CW-1:0]   rel_cnt, rel_next;
  logic [NCOL-1:0] col_q, col_next;
  logic [3:0]      key_q, key_next;
  logic            valid_q, valid_next;
  logic            held_q, held_next;
  logic            sample;

  row_sync u_row_sync (
    .clk   (clk),
    .reset (reset),
    .row   (kp.row),
    .rs    (rs)
  );

  assign sample = (dwell == DWELL_LAST);

  // Free-running dwell counter; rows are sampled on its last count so the
  // freshly driven column has settled through the synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dwell <= '0;
    else if (sample) dwell <= '0;
    else dwell <= dwell + DW'(1);
  end

  // Next-state logic for scan, debounce and held phases plus the key report.
  always_comb begin
    state_next    = state;
    col_idx_next  = col_idx;
    cand_row_next = cand_row;
    cand_col_next = cand_col;
    match_next    = match_cnt;
    rel_next      = rel_cnt;
    key_next      = key_q;
    valid_next    = 1'b0;
    held_next     = held_q;

    case (state)
      SCAN: begin
        if (sample) begin
          if (rs == COL_IDLE) begin
            col_idx_next = col_idx + IW'(1);
          end else begin
            cand_row_next = lowest_low(rs);
            cand_col_next = col_idx;
            if (DEBOUNCE_CNT == 1) begin
              key_next   = {lowest_low(rs), col_idx};
              valid_next = 1'b1;
              held_next  = 1'b1;
              rel_next   = '0;
              match_next = '0;
              state_next = HELD;
            end else begin
              match_next = CW'(1);
              state_next = DEBOUNCE;
            end
          end
        end
      end

      DEBOUNCE: begin
        if (sample) begin
          if (!rs[cand_row]) begin
            if (match_cnt + CW'(1) == CNT_DONE) begin
              key_next   = {cand_row, cand_col};
              valid_next = 1'b1;
              held_next  = 1'b1;
              rel_next   = '0;
              match_next = '0;
              state_next = HELD;
            end else begin
              match_next = match_cnt + CW'(1);
            end
          end else begin
            match_next   = '0;
            col_idx_next = col_idx + IW'(1);
            state_next   = SCAN;
          end
        end
      end

      HELD: begin
        if (sample) begin
          if (rs == COL_IDLE) begin
            if (rel_cnt + CW'(1) == CNT_DONE) begin
              held_next    = 1'b0;
              rel_next     = '0;
              col_idx_next = col_idx + IW'(1);
              state_next   = SCAN;
            end else begin
              rel_next = rel_cnt + CW'(1);
            end
          end else begin
            rel_next = '0;
          end
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase

    col_next = col_drive(col_idx_next);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      cand_row  <= '0;
      cand_col  <= '0;
      match_cnt <= '0;
      rel_cnt   <= '0;
      col_q     <= 4'b1110;
      key_q     <= 4'h0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state     <= state_next;
      col_idx   <= col_idx_next;
      cand_row  <= cand_row_next;
      cand_col  <= cand_col_next;
      match_cnt <= match_next;
      rel_cnt   <= rel_next;
      col_q     <= col_next;
      key_q     <= key_next;
      valid_q   <= valid_next;
      held_q    <= held_next;
    end
  end

  assign kp.col       = col_q;
  assign kp.key       = key_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a modelled 4x4 key matrix.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_key;
  logic prev_valid = 1'b0;

  int start;
  int lat;
  int run;
  int changes;
  logic [3:0] prev_col;

  // 100 MHz system clock.
  always #5 clk = ~clk;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  // Key matrix: a pressed key (r,c) shorts row r to column c.
  always_comb begin
    kp.row = '1;
    for (int r = 0; r < 4; r++) begin
      kp.row[r] = &(kp.col | ~pressed[r*4 +: 4]);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] key_mask(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  // Drive the key matrix and, if an acceptance is expected, queue its code.
  task automatic applyStimulus(input logic [15:0] mask, input bit expect_accept,
                               input logic [3:0] code);
    pressed = mask;
    if (expect_accept) exp_q.push_back(code);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int s;
    s = pulse_count;
    for (int i = 0; i < budget && pulse_count == s; i++) step(1);
    checkOutput(tag, pulse_count - s, 1);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] target, input int budget);
    for (int i = 0; i < budget && kp.col != target; i++) step(1);
    checkOutput(tag, kp.col, target);
  endtask

  task automatic wait_release(input string tag, input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget && kp.key_held; i++) begin
      step(1);
      cycles++;
    end
    checkOutput(tag, kp.key_held, 0);
  endtask

  // Scoreboard monitor: every valid pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (kp.key_valid) begin
        pulse_count++;
        checkOutput("valid_consecutive", 32'(prev_valid), 0);
        checkOutput("valid_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_key = exp_q.pop_front();
          checkOutput("valid_key", kp.key, exp_key);
          checkOutput("valid_held", kp.key_held, 1);
        end
      end
      prev_valid = kp.key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    step(3);
    checkOutput("reset_col", kp.col, 4'b1110);
    checkOutput("reset_key", kp.key, 4'h0);
    checkOutput("reset_valid", kp.key_valid, 0);
    checkOutput("reset_held", kp.key_held, 0);
    reset = 1'b1;

    // Idle scan: each column in turn for four cycles, no reports.
    prev_col = kp.col;
    run = 0;
    changes = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      run++;
      if (kp.col != prev_col) begin
        checkOutput("idle_col_order", kp.col, {prev_col[2:0], prev_col[3]});
        if (changes > 0) checkOutput("idle_dwell", run, 4);
        changes++;
        run = 0;
        prev_col = kp.col;
      end
    end
    checkOutput("idle_changes", changes, 16);
    checkOutput("idle_no_valid", pulse_count, 0);

    // Press (2,1) and hold.
    applyStimulus(key_mask(2, 1), 1, 4'b1001);
    wait_pulse("press21_valid", 60);
    step(40);
    checkOutput("press21_single", pulse_count, 1);
    checkOutput("press21_held", kp.key_held, 1);
    checkOutput("press21_col", kp.col, 4'b1101);
    checkOutput("press21_key", kp.key, 4'b1001);

    // Release: held drops on the third all-high sample, col moves on.
    applyStimulus('0, 0, 4'h0);
    wait_release("release21_held", 40, lat);
    checkOutput("release21_latency", 32'(lat >= 11 && lat <= 14), 1);
    checkOutput("release21_col", kp.col, 4'b1011);
    checkOutput("release21_key", kp.key, 4'b1001);

    // Glitch on (1,3): detected, then lost during debounce.
    wait_col("glitch_wait_col3", 4'b0111, 40);
    start = pulse_count;
    applyStimulus(key_mask(1, 3), 0, 4'h0);
    step(6);
    applyStimulus('0, 0, 4'h0);
    step(2);
    checkOutput("glitch_col_frozen", kp.col, 4'b0111);
    for (int i = 0; i < 20 && kp.col == 4'b0111; i++) step(1);
    checkOutput("glitch_resume_col", kp.col, 4'b1110);
    checkOutput("glitch_no_valid", pulse_count - start, 0);

    // Two keys in column 2; lowest row wins, later key in HELD is ignored.
    applyStimulus(key_mask(0, 2) | key_mask(3, 2), 1, 4'b0010);
    wait_pulse("multi_valid", 60);
    start = pulse_count;
    applyStimulus(key_mask(0, 2) | key_mask(3, 2) | key_mask(1, 0), 0, 4'h0);
    step(40);
    checkOutput("multi_no_rollover", pulse_count - start, 0);
    checkOutput("multi_held", kp.key_held, 1);
    checkOutput("multi_key", kp.key, 4'b0010);
    checkOutput("multi_col", kp.col, 4'b1011);
    applyStimulus('0, 0, 4'h0);
    wait_release("multi_release", 40, lat);

    // Reset while debouncing (2,1).
    wait_col("rstdeb_wait_col1", 4'b1101, 40);
    applyStimulus(key_mask(2, 1), 0, 4'h0);
    step(6);
    checkOutput("rstdeb_pre_col", kp.col, 4'b1101);
    reset = 1'b0;
    #1;
    checkOutput("rstdeb_col", kp.col, 4'b1110);
    checkOutput("rstdeb_key", kp.key, 4'h0);
    checkOutput("rstdeb_valid", kp.key_valid, 0);
    checkOutput("rstdeb_held", kp.key_held, 0);
    step(3);
    applyStimulus(key_mask(2, 1), 1, 4'b1001);
    reset = 1'b1;
    wait_pulse("rstdeb_reaccept", 60);

    // Reset while the key is held.
    step(5);
    checkOutput("rstheld_pre_held", kp.key_held, 1);
    reset = 1'b0;
    #1;
    checkOutput("rstheld_col", kp.col, 4'b1110);
    checkOutput("rstheld_key", kp.key, 4'h0);
    checkOutput("rstheld_valid", kp.key_valid, 0);
    checkOutput("rstheld_held", kp.key_held, 0);
    step(3);
    applyStimulus(key_mask(2, 1), 1, 4'b1001);
    reset = 1'b1;
    wait_pulse("rstheld_reaccept", 60);
    step(10);
    applyStimulus('0, 0, 4'h0);
    wait_release("final_release", 40, lat);

    checkOutput("total_pulses", pulse_count, 4);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
